// File: rtl/uart_axil_ctrl_pkg.sv
// Shared definitions for the UART Lite AXI4-Lite controller:
// register map, status bits, response codes and the controller state type.
package uart_axil_pkg;

    localparam logic [7:0] REG_RX_FIFO = 8'h0;
    localparam logic [7:0] REG_TX_FIFO = 8'h4;
    localparam logic [7:0] REG_STAT    = 8'h8;
    localparam logic [7:0] REG_CTRL    = 8'hC;

    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_TX_FULL  = 3;

    localparam logic [1:0] OKAY = 2'b00;

    typedef enum logic [3:0] {
        INIT_AW,
        INIT_B,
        IDLE,
        STAT_AR,
        STAT_R,
        TX_AW,
        TX_B,
        RX_AR,
        RX_R
    } state_e;

endpackage

// File: rtl/uart_axil_ctrl_if.sv
// AXI4-Lite bus bundle (no wstrb/prot) between the controller and the UART Lite IP.
interface uart_axil_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/uart_axil_ctrl_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is the oldest entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
        head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end
endmodule

// File: rtl/uart_axil_ctrl.sv
// AXI4-Lite master for the UART Lite IP: buffers TX bytes, polls STAT,
// writes TX_FIFO when space exists, and drains RX into a one-entry holding register.
module uart_axil_ctrl
    import uart_axil_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TX_DEPTH  = 16,
    parameter logic [7:0]  CTRL_INIT = 8'h03,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned POLL_DIV  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             valid,
    output logic             ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err,
    output logic [7:0]       err_cnt,
    uart_axil_ctrl_if.master axi
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int unsigned POLL_W  = $clog2(POLL_DIV + 2);

    state_e             state_q, state_d;
    logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       resp_err, in_init;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign in_init   = (state_q == INIT_AW) || (state_q == INIT_B);
    assign ready     = !in_init && !fifo_full;
    assign fifo_push = valid && ready;

    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.arvalid = arvalid_q;
    assign axi.bready  = (state_q == INIT_B) || (state_q == TX_B);
    assign axi.rready  = (state_q == STAT_R) || (state_q == RX_R);
    assign axi.awaddr  = (state_q == TX_AW) ? ADDR_W'(REG_TX_FIFO) : ADDR_W'(REG_CTRL);
    assign axi.wdata   = (state_q == TX_AW) ? DATA_W'(fifo_head) : DATA_W'(CTRL_INIT);
    assign axi.araddr  = (state_q == RX_AR) ? ADDR_W'(REG_RX_FIFO) : ADDR_W'(REG_STAT);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        retry_d    = retry_q;
        poll_d     = poll_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        fifo_pop   = 1'b0;
        resp_err   = 1'b0;

        unique case (state_q)
            INIT_AW, TX_AW: begin
                // AW and W complete independently; each valid stays up until its own handshake.
                aw_done_d = aw_done_q || (awvalid_q && axi.awready);
                w_done_d  = w_done_q  || (wvalid_q && axi.wready);
                awvalid_d = !aw_done_d;
                wvalid_d  = !w_done_d;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (state_q == INIT_AW) ? INIT_B : TX_B;
                end
            end
            INIT_B, TX_B: begin
                if (axi.bvalid) begin
                    if (axi.bresp == OKAY) begin
                        retry_d  = '0;
                        fifo_pop = (state_q == TX_B);
                        state_d  = IDLE;
                    end else begin
                        resp_err = 1'b1;
                        state_d  = (state_q == INIT_B) ? INIT_AW : TX_AW;
                    end
                end
            end
            IDLE: begin
                if (poll_q != '0) poll_d = poll_q - POLL_W'(1);
                if (!fifo_empty || (POLL_DIV != 0 && poll_q == '0 && !rx_valid_q)) begin
                    poll_d  = POLL_W'(POLL_DIV);
                    state_d = STAT_AR;
                end
            end
            STAT_AR, RX_AR: begin
                arvalid_d = 1'b1;
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = (state_q == STAT_AR) ? STAT_R : RX_R;
                end
            end
            STAT_R: begin
                if (axi.rvalid) begin
                    if (axi.rresp == OKAY) begin
                        retry_d = '0;
                        if (axi.rdata[STAT_RX_VALID] && !rx_valid_q)
                            state_d = RX_AR;
                        else if (!fifo_empty && !axi.rdata[STAT_TX_FULL])
                            state_d = TX_AW;
                        else
                            state_d = IDLE;
                    end else begin
                        resp_err = 1'b1;
                        state_d  = STAT_AR;
                    end
                end
            end
            RX_R: begin
                if (axi.rvalid) begin
                    if (axi.rresp == OKAY) begin
                        retry_d    = '0;
                        rx_data_d  = axi.rdata[7:0];
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        resp_err = 1'b1;
                        state_d  = RX_AR;
                    end
                end
            end
            default: state_d = INIT_AW;
        endcase

        // All response states share one retry budget; exhausting it drops the transaction.
        if (resp_err) begin
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
                retry_d   = '0;
                err_d     = 1'b1;
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                fifo_pop  = (state_q == TX_B);
                state_d   = IDLE;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_AW;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            retry_q    <= '0;
            poll_q     <= POLL_W'(POLL_DIV);
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            retry_q    <= retry_d;
            poll_q     <= poll_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule
